// File: rtl/breakdown_classify_if.sv
// ----------------------------------------------------------------------------
// breakdown_classify_if: ADC sample inputs and classification outputs of the gap classifier
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface breakdown_classify_if #(
   parameter int DATA_W = 16,
   parameter int CNT_W  = 16
);
   logic signed [DATA_W-1:0] sample_current;
   logic signed [DATA_W-1:0] sample_voltage;
   logic                     sample_valid;
   logic [7:0]               current_state;
   logic                     is_breakdown;
   logic                     is_short;
   logic                     is_open_timeout;
   logic [1:0]               gap_class;
   logic [CNT_W-1:0]         ignition_delay;
   logic                     ignition_delay_valid;

   modport master (
      output sample_current, sample_voltage, sample_valid, current_state,
      input  is_breakdown, is_short, is_open_timeout, gap_class,
             ignition_delay, ignition_delay_valid
   );

   modport slave (
      input  sample_current, sample_voltage, sample_valid, current_state,
      output is_breakdown, is_short, is_open_timeout, gap_class,
             ignition_delay, ignition_delay_valid
   );
endinterface

`default_nettype wire

// File: rtl/breakdown_classify.sv
// ----------------------------------------------------------------------------
// breakdown_classify: breakdown / short / open-timeout gap classifier with ignition delay
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module breakdown_classify #(
   parameter int                DATA_W                  = 16,
   parameter int                CNT_W                   = 16,
   parameter logic [7:0]        WAIT_STATE_CODE         = 8'b00000001,
   parameter logic [1:0]        DETECT_MODE             = 2'd0,
   parameter logic [DATA_W-1:0] DEION_THRESHOLD_VOL     = 16'd8,
   parameter logic [DATA_W-1:0] BREAKDOWN_THRESHOLD_VOL = 16'd35,
   parameter logic [DATA_W-1:0] BREAKDOWN_THRESHOLD_CUR = 16'd10,
   parameter logic [CNT_W-1:0]  QUALIFY_TIME            = 16'd10,
   parameter logic [CNT_W-1:0]  GLITCH_TOL              = 16'd2,
   parameter logic [CNT_W-1:0]  SHORT_TIME              = 16'd50,
   parameter logic [CNT_W-1:0]  OPEN_TIMEOUT            = 16'd10000
) (
   input  logic                clk,
   input  logic                rst_n,
   breakdown_classify_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_MONITOR   = 3'd1,
      S_BREAKDOWN = 3'd2,
      S_SHORT     = 3'd3,
      S_TIMEOUT   = 3'd4
   } state_t;

   // A zero qualify/short length would classify on wait entry; clamp to one sample.
   localparam logic [CNT_W-1:0] QUAL_EFF  = (QUALIFY_TIME == '0) ? CNT_W'(1) : QUALIFY_TIME;
   localparam logic [CNT_W-1:0] SHORT_EFF = (SHORT_TIME == '0) ? CNT_W'(1) : SHORT_TIME;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
      return (&x) ? x : x + CNT_W'(1);
   endfunction

   state_t           state_q, state_d;
   logic [CNT_W-1:0] delay_cnt_q, delay_cnt_d;
   logic [CNT_W-1:0] qual_cnt_q, qual_cnt_d;
   logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
   logic [CNT_W-1:0] short_cnt_q, short_cnt_d;
   logic [CNT_W-1:0] ign_delay_q, ign_delay_d;
   logic             ign_valid_q, ign_valid_d;
   logic             vol_ok_q, vol_ok_d;
   logic             cur_ok_q, cur_ok_d;
   logic             short_hit_q, short_hit_d;
   logic             valid_q, valid_d;
   logic             hit;
   logic             in_wait;
   logic [CNT_W-1:0] miss_inc;

   assign in_wait = (bus.current_state == WAIT_STATE_CODE);

   // Threshold compares are registered once per sample; the FSM consumes them a cycle later.
   always_comb begin
      vol_ok_d    = ($signed(bus.sample_voltage) >= $signed(DEION_THRESHOLD_VOL)) &&
                    ($signed(bus.sample_voltage) <= $signed(BREAKDOWN_THRESHOLD_VOL));
      cur_ok_d    = ($signed(bus.sample_current) >= $signed(BREAKDOWN_THRESHOLD_CUR));
      short_hit_d = ($signed(bus.sample_voltage) < $signed(DEION_THRESHOLD_VOL)) && cur_ok_d;
      valid_d     = bus.sample_valid;
   end

   always_comb begin
      hit = vol_ok_q;
      case (DETECT_MODE)
         2'd1:    hit = vol_ok_q & cur_ok_q;
         2'd2:    hit = vol_ok_q | cur_ok_q;
         default: hit = vol_ok_q;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      delay_cnt_d = delay_cnt_q;
      qual_cnt_d  = qual_cnt_q;
      miss_cnt_d  = miss_cnt_q;
      short_cnt_d = short_cnt_q;
      ign_delay_d = ign_delay_q;
      ign_valid_d = 1'b0;
      miss_inc    = sat_inc(miss_cnt_q);

      if (!in_wait) begin
         state_d     = S_IDLE;
         delay_cnt_d = '0;
         qual_cnt_d  = '0;
         miss_cnt_d  = '0;
         short_cnt_d = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               state_d     = S_MONITOR;
               delay_cnt_d = '0;
               qual_cnt_d  = '0;
               miss_cnt_d  = '0;
               short_cnt_d = '0;
            end
            S_MONITOR: begin
               delay_cnt_d = sat_inc(delay_cnt_q);
               if (valid_q) begin
                  if (hit) begin
                     qual_cnt_d = sat_inc(qual_cnt_q);
                     miss_cnt_d = '0;
                  end else if (miss_inc > GLITCH_TOL) begin
                     qual_cnt_d = '0;
                     miss_cnt_d = '0;
                  end else begin
                     miss_cnt_d = miss_inc;
                  end
                  short_cnt_d = short_hit_q ? sat_inc(short_cnt_q) : '0;
               end
               // Decide on next-count values so the flag rises with the final sample.
               if (short_cnt_d >= SHORT_EFF) begin
                  state_d = S_SHORT;
               end else if (qual_cnt_d >= QUAL_EFF) begin
                  state_d     = S_BREAKDOWN;
                  ign_delay_d = delay_cnt_d;
                  ign_valid_d = 1'b1;
               end else if ((OPEN_TIMEOUT != '0) && (delay_cnt_d >= OPEN_TIMEOUT)) begin
                  state_d = S_TIMEOUT;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         delay_cnt_q <= '0;
         qual_cnt_q  <= '0;
         miss_cnt_q  <= '0;
         short_cnt_q <= '0;
         ign_delay_q <= '0;
         ign_valid_q <= 1'b0;
         vol_ok_q    <= 1'b0;
         cur_ok_q    <= 1'b0;
         short_hit_q <= 1'b0;
         valid_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         delay_cnt_q <= delay_cnt_d;
         qual_cnt_q  <= qual_cnt_d;
         miss_cnt_q  <= miss_cnt_d;
         short_cnt_q <= short_cnt_d;
         ign_delay_q <= ign_delay_d;
         ign_valid_q <= ign_valid_d;
         vol_ok_q    <= vol_ok_d;
         cur_ok_q    <= cur_ok_d;
         short_hit_q <= short_hit_d;
         valid_q     <= valid_d;
      end
   end

   always_comb begin
      bus.gap_class = 2'd0;
      case (state_q)
         S_BREAKDOWN: bus.gap_class = 2'd1;
         S_SHORT:     bus.gap_class = 2'd2;
         S_TIMEOUT:   bus.gap_class = 2'd3;
         default:     bus.gap_class = 2'd0;
      endcase
   end

   assign bus.is_breakdown         = (state_q == S_BREAKDOWN);
   assign bus.is_short             = (state_q == S_SHORT);
   assign bus.is_open_timeout      = (state_q == S_TIMEOUT);
   assign bus.ignition_delay       = ign_delay_q;
   assign bus.ignition_delay_valid = ign_valid_q;

endmodule

`default_nettype wire
